// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: legal active-low patterns (abcdefg, a first),
// the blank pattern and the capture FSM state encoding.
package seg7_pkg;

   localparam logic [0:6] SEG_HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble.
// Anything outside the 16 legal glyphs (blank included) is reported illegal.
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [0:6] pattern,
   output logic [3:0] nibble,
   output logic       illegal
);

   // Search the glyph table; at most one entry can match.
   always_comb begin
      nibble  = 4'h0;
      illegal = 1'b1;
      for (int i = 0; i < 16; i++) begin
         nibble  = (pattern == SEG_HEX[i]) ? 4'(i) : nibble;
         illegal = (pattern == SEG_HEX[i]) ? 1'b0  : illegal;
      end
   end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low seven-segment bus and recovers one hex
// nibble per digit once its pattern has dwelt for STABLE_CYCLES samples.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int DIGITS        = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [0:6]            seg,
   input  logic [DIGITS-1:0]     dig_en,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     err,
   output logic                  frame_valid
);

   localparam logic [7:0]        STABLE_C  = 8'(STABLE_CYCLES);
   localparam logic [DIGITS-1:0] DEN_ZERO  = {DIGITS{1'b0}};
   localparam logic [DIGITS-1:0] DEN_ONE   = DIGITS'(1);
   localparam logic [DIGITS-1:0] MASK_FULL = {DIGITS{1'b1}};

   logic [0:6]          seg_r;
   logic [0:6]          seg_prev_r;
   logic [DIGITS-1:0]   den_r;
   logic [DIGITS-1:0]   den_prev_r;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [7:0]          cnt_r;
   logic [7:0]          cnt_nxt_s;
   logic [7:0]          cnt_inc_s;

   logic                change_s;
   logic                onehot_s;
   logic                capture_s;
   logic [3:0]          nib_s;
   logic                illegal_s;

   logic [4*DIGITS-1:0] value_r;
   logic [DIGITS-1:0]   err_r;
   logic [DIGITS-1:0]   mask_r;
   logic [DIGITS-1:0]   mask_set_s;
   logic                frame_r;

   seg7_to_hex u_dec (
      .pattern (seg_r),
      .nibble  (nib_s),
      .illegal (illegal_s)
   );

   // Input register plus a one-sample history used for change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r      <= 7'b0000000;
         seg_prev_r <= 7'b0000000;
         den_r      <= DEN_ZERO;
         den_prev_r <= DEN_ZERO;
      end else begin
         seg_r      <= seg;
         seg_prev_r <= seg_r;
         den_r      <= dig_en;
         den_prev_r <= den_r;
      end
   end

   assign change_s   = (seg_r != seg_prev_r) || (den_r != den_prev_r);
   assign onehot_s   = (den_r != DEN_ZERO) && ((den_r & (den_r - DEN_ONE)) == DEN_ZERO);
   assign cnt_inc_s  = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
   assign mask_set_s = mask_r | den_r;

   // FSM state and dwell counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next state: any change restarts the dwell at 1; a non-one-hot enable parks in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (onehot_s) begin
               state_nxt_s = SETTLE;
               cnt_nxt_s   = 8'd1;
            end else begin
               cnt_nxt_s   = 8'd0;
            end
         end
         SETTLE: begin
            if (!onehot_s) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 8'd0;
            end else if (change_s) begin
               cnt_nxt_s   = 8'd1;
            end else if (cnt_inc_s == STABLE_C) begin
               state_nxt_s = HELD;
               cnt_nxt_s   = cnt_inc_s;
            end else begin
               cnt_nxt_s   = cnt_inc_s;
            end
         end
         HELD: begin
            if (!onehot_s) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 8'd0;
            end else if (change_s) begin
               state_nxt_s = SETTLE;
               cnt_nxt_s   = 8'd1;
            end else begin
               cnt_nxt_s   = cnt_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 8'd0;
         end
      endcase
   end

   // Capture fires on the single SETTLE->HELD transition.
   always_comb begin
      capture_s = 1'b0;
      case (state_r)
         SETTLE:  capture_s = (state_nxt_s == HELD);
         default: capture_s = 1'b0;
      endcase
   end

   // Per-digit storage, error flags and frame mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_r <= {(4*DIGITS){1'b0}};
         err_r   <= DEN_ZERO;
         mask_r  <= DEN_ZERO;
         frame_r <= 1'b0;
      end else begin
         frame_r <= 1'b0;
         if (capture_s) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (den_r[i]) begin
                  if (!illegal_s) begin
                     value_r[4*i +: 4] <= nib_s;
                     err_r[i]          <= 1'b0;
                  end else begin
                     err_r[i]          <= 1'b1;
                  end
               end
            end
            if (mask_set_s == MASK_FULL) begin
               frame_r <= 1'b1;
               mask_r  <= DEN_ZERO;
            end else begin
               mask_r  <= mask_set_s;
            end
         end
      end
   end

   assign value       = value_r;
   assign err         = err_r;
   assign frame_valid = frame_r;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed table, latency/reset sequences
// and randomized traffic against a run-length reference model.
module tb_seg7_capture;

   localparam int DIGITS = 2;
   localparam int STABLE = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:6] seg;
   logic [1:0] dig_en;
   logic [7:0] value;
   logic [1:0] err;
   logic       frame_valid;

   always #5 clk = ~clk;

   seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .dig_en      (dig_en),
      .value       (value),
      .err         (err),
      .frame_valid (frame_valid)
   );

   logic [0:6] pat [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int errors = 0;
   int checks = 0;
   int frames_seen = 0;

   // reference model: expected outputs plus the run length of the current input sample
   logic [7:0] m_value;
   logic [1:0] m_err;
   logic [1:0] m_mask;
   logic       m_frame;
   logic [0:6] m_prev_seg;
   logic [1:0] m_prev_den;
   int         m_run;

   typedef struct {
      logic [0:6] seg;
      logic [1:0] den;
      int         cycles;
      logic [7:0] exp_value;
      logic [1:0] exp_err;
      int         exp_frames;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic lookup(input logic [0:6] s, output logic [3:0] n, output bit ok);
      n  = 4'h0;
      ok = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (pat[k] == s) begin
            n  = 4'(k);
            ok = 1'b1;
         end
      end
   endtask

   task automatic model_reset();
      m_value    = 8'h00;
      m_err      = 2'b00;
      m_mask     = 2'b00;
      m_frame    = 1'b0;
      m_prev_seg = 7'b0000000;
      m_prev_den = 2'b00;
      m_run      = 0;
   endtask

   // A digit is captured on the edge after its sample has been seen exactly STABLE times in a row.
   task automatic model_edge(input logic [0:6] s, input logic [1:0] d);
      logic [3:0] nib;
      bit         ok;
      m_frame = 1'b0;
      if (m_run == STABLE && $countones(m_prev_den) == 1) begin
         lookup(m_prev_seg, nib, ok);
         for (int k = 0; k < DIGITS; k++) begin
            if (m_prev_den[k]) begin
               if (ok) begin
                  m_value[4*k +: 4] = nib;
                  m_err[k] = 1'b0;
               end else begin
                  m_err[k] = 1'b1;
               end
               m_mask[k] = 1'b1;
            end
         end
         if (m_mask == 2'b11) begin
            m_frame = 1'b1;
            m_mask  = 2'b00;
         end
      end
      if (s == m_prev_seg && d == m_prev_den) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_run = 1;
      end
      m_prev_seg = s;
      m_prev_den = d;
   endtask

   task automatic step(input logic [0:6] s, input logic [1:0] d);
      seg    = s;
      dig_en = d;
      @(posedge clk);
      model_edge(s, d);
      #1;
      check("model_value", {24'h0, value}, {24'h0, m_value});
      check("model_err", {30'h0, err}, {30'h0, m_err});
      check("model_frame", {31'h0, frame_valid}, {31'h0, m_frame});
      if (frame_valid) frames_seen++;
   endtask

   initial begin
      logic [0:6] rs;
      logic [1:0] rd;
      int         sel;
      int         hold;

      tbl[0] = '{7'b0100100, 2'b01, 6,  8'h05, 2'b00, 0};
      tbl[1] = '{7'b0001000, 2'b10, 6,  8'hA5, 2'b00, 1};
      tbl[2] = '{7'b0000110, 2'b01, 3,  8'hA5, 2'b00, 0};
      tbl[3] = '{7'b0000111, 2'b01, 1,  8'hA5, 2'b00, 0};
      tbl[4] = '{7'b0000110, 2'b01, 6,  8'hA3, 2'b00, 0};
      tbl[5] = '{7'b1111111, 2'b01, 6,  8'hA3, 2'b01, 0};
      tbl[6] = '{7'b0000001, 2'b01, 6,  8'hA0, 2'b00, 0};
      tbl[7] = '{7'b0000000, 2'b11, 20, 8'hA0, 2'b00, 0};
      tbl[8] = '{7'b0000000, 2'b00, 20, 8'hA0, 2'b00, 0};
      tbl[9] = '{7'b1100000, 2'b10, 6,  8'hB0, 2'b00, 1};

      rst_n  = 1'b0;
      seg    = 7'b1111111;
      dig_en = 2'b00;
      model_reset();
      #23;
      check("reset_value", {24'h0, value}, 32'h0);
      check("reset_err", {30'h0, err}, 32'h0);
      check("reset_frame", {31'h0, frame_valid}, 32'h0);
      rst_n = 1'b1;
      #1;

      // latency: first sample at edge 1, nibble appears at edge 1+STABLE
      for (int c = 0; c < STABLE; c++) step(7'b0100100, 2'b01);
      check("latency_before", {24'h0, value}, 32'h00);
      step(7'b0100100, 2'b01);
      check("latency_at", {24'h0, value}, 32'h05);

      for (int v = 0; v < 10; v++) begin
         frames_seen = 0;
         for (int c = 0; c < tbl[v].cycles; c++) step(tbl[v].seg, tbl[v].den);
         check($sformatf("tbl%0d_value", v), {24'h0, value}, {24'h0, tbl[v].exp_value});
         check($sformatf("tbl%0d_err", v), {30'h0, err}, {30'h0, tbl[v].exp_err});
         check($sformatf("tbl%0d_frames", v), frames_seen, tbl[v].exp_frames);
      end

      // asynchronous reset in the middle of a dwell
      for (int c = 0; c < 4; c++) step(7'b0001111, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_value", {24'h0, value}, 32'h0);
      check("async_rst_err", {30'h0, err}, 32'h0);
      check("async_rst_frame", {31'h0, frame_valid}, 32'h0);
      model_reset();
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < STABLE; c++) step(7'b0001111, 2'b01);
      check("post_rst_hold", {24'h0, value}, 32'h00);
      step(7'b0001111, 2'b01);
      check("post_rst_capture", {24'h0, value}, 32'h07);

      // randomized traffic against the model
      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)      rs = pat[$urandom_range(0, 15)];
         else if (sel < 8) rs = 7'($urandom);
         else              rs = 7'b1111111;
         sel = $urandom_range(0, 9);
         if (sel < 4)      rd = 2'b01;
         else if (sel < 8) rd = 2'b10;
         else if (sel < 9) rd = 2'b00;
         else              rd = 2'b11;
         hold = $urandom_range(1, 7);
         for (int c = 0; c < hold; c++) step(rs, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the hex-to-seven-segment decoder: samples a time-multiplexed, active-low seven-segment bus (segments plus digit enables) and recovers the hexadecimal value of each digit. Used in board-level self-test to read back what the display path is driving, and to decode segment patterns from external modules. Each digit is accepted only after its pattern holds steady for a programmable dwell. Invalid patterns are flagged per digit, and a one-cycle strobe marks a complete frame.

## Interface
- `DIGITS`, default 2: number of multiplexed digits, 1..8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before capture, 2..255.
- `clk` input, 1 bit: single clock; all state on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `seg` input, [0:6]: segment lines, active-low, seg[0]=a … seg[6]=g; 0 = segment lit.
- `dig_en` input, [DIGITS-1:0]: digit enables, active-high, expected one-hot.
- `value` output, [4*DIGITS-1:0]: recovered nibbles; digit i occupies bits [4i+3:4i].
- `err` output, [DIGITS-1:0]: per-digit flag; 1 = last capture for that digit was not a legal pattern.
- `frame_valid` output, 1 bit: one-cycle pulse when every digit has been captured since the previous pulse.

## Operation
- Input stage: `seg` and `dig_en` are registered once; all logic below uses the registered copies.
- Legal patterns, abcdefg active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Every other pattern, including 1111111 (blank), is illegal.
- State machine, 3 states:
  - IDLE: registered `dig_en` not one-hot (zero or multiple bits). Counter held at 0. Go to SETTLE once `dig_en` is one-hot.
  - SETTLE: counter increments each cycle that `seg` and `dig_en` equal the previous sample. On any change, counter resets to 1 and the state stays SETTLE (or goes to IDLE if `dig_en` is not one-hot). When counter reaches STABLE_CYCLES, capture and go to HELD.
  - HELD: no further capture. Any change of `seg` or `dig_en` goes to SETTLE with counter 1, or to IDLE if not one-hot.
- Capture on digit i:
  - Legal pattern: nibble i gets the decoded value and err[i] is cleared.
  - Illegal pattern: nibble i keeps its previous value and err[i] is set.
  - In both cases captured_mask[i] is set.
- Frame: when captured_mask is all ones after a capture, `frame_valid` pulses for one cycle and captured_mask clears in the same edge.
- Recapturing a digit already present in captured_mask overwrites nibble and err but does not change the mask.
- Counter width: 8 bits, saturating; it never wraps.

## Timing
- Reset values: value = 0, err = 0, frame_valid = 0, captured_mask = 0, state = IDLE, counter = 0. These take effect immediately on `rst_n` low, including mid-dwell; no partial frame survives reset.
- Latency: a pattern stable from input edge t updates `value`/`err` at edge t+STABLE_CYCLES, counting 1 cycle for the input register.
- `frame_valid` asserts on the same edge as the completing digit's update and lasts exactly 1 cycle.
- A change on the cycle the counter would reach STABLE_CYCLES wins: no capture, counter = 1.
- Minimum dwell per digit for capture is STABLE_CYCLES+1 clk cycles, including the input register.

## Structure
- Package `seg7_pkg` holds:
  - the 16 legal segment-pattern constants, shared with the existing display decoder;
  - the blank pattern 7'b1111111;
  - the state enum {IDLE, SETTLE, HELD}.
- Sub-module `seg7_to_hex`: combinational pattern→{nibble, illegal} lookup; the only decode logic in the block.
- Top level: input register, counter/FSM, per-digit storage, frame mask.

## Test plan
- Reset/basic: DIGITS=2, STABLE_CYCLES=4. After reset check value=8'h00, err=0. Drive dig_en=01, seg=0100100 for 6 cycles -> value[3:0]=5 at input edge +4, err[0]=0, no frame_valid.
- Frame: continue from the previous test with dig_en=10, seg=0001000 for 6 cycles -> value=8'hA5, one frame_valid pulse, captured_mask cleared.
- Glitch: dig_en=01, seg=0000110 for 3 cycles, 1 cycle of 0000111, then 0000110 for 6 cycles -> no capture during the glitch; capture of 3 only 4 edges after the glitch ends.
- Illegal/blank: digit 0 holds 3, then seg=1111111 for 6 cycles -> err[0]=1, value[3:0] stays 3. Next legal 0 clears err[0].
- Non-one-hot: dig_en=11 or 00 with a stable legal pattern for 20 cycles -> no capture, state IDLE.
- Async reset mid-dwell: rst_n low at counter 3 -> all outputs 0 immediately. After release, a full STABLE_CYCLES dwell is needed before capture.
